// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 issue stage: widths, op codes, FSM states.
package alu32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR = 3'b011;
  localparam logic [OP_W-1:0] OP_SLT = 3'b100;
  localparam logic [OP_W-1:0] OP_ADD = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_MOD = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_MOD_WAIT  = 3'd2,
    ST_MOD_DRAIN = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Only the modulo op goes through the start/done handshake.
  function automatic logic is_mod(input logic [OP_W-1:0] op);
    return op == OP_MOD;
  endfunction

endpackage

// File: rtl/alu32_seq_wdog.sv
// Watchdog for one MOD handshake phase: load clears, enable counts,
// expire is raised on the TIMEOUT_CYCLES-th enabled cycle after a load.
module alu32_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Next count: load wins, otherwise count while enabled and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu32_seq_ctrl.sv
// Issue stage in front of alu32: accepts a request, holds the operands on the
// ALU inputs, runs the MOD start/done handshake, and returns the captured
// result on a valid/ready response port.
// Optional feature macro: ALU_SEQ_TIMEOUT_EN (MOD phase timeout with rsp_err).
module alu32_seq_ctrl
  import alu32_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_s_q, alu_s_d;
  logic              alu_start_q, alu_start_d;
  logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
  logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic wd_load, wd_en, wd_expire;

  // Restart the watchdog on MOD accept and again when done is first seen,
  // so each handshake phase gets its own full budget.
  assign wd_load = ((state_q == ST_IDLE) && req_valid && is_mod(req_op)) ||
                   ((state_q == ST_MOD_WAIT) && alu_done);
  assign wd_en   = (state_q == ST_MOD_WAIT) || (state_q == ST_MOD_DRAIN);

  alu32_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .load  (wd_load),
    .en    (wd_en),
    .expire(wd_expire)
  );

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign alu_start = alu_start_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_op    = rsp_op_q;

  // Next-state and register updates; everything holds unless a transition says otherwise.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    alu_start_d = alu_start_q;
    rsp_res_d   = rsp_res_q;
    rsp_op_d    = rsp_op_q;
    cnt_d       = cnt_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d = req_a;
          alu_b_d = req_b;
          alu_s_d = req_op;
          if (is_mod(req_op)) begin
            alu_start_d = 1'b1;
            state_d     = ST_MOD_WAIT;
          end else begin
            cnt_d   = '0;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // The extra count step gives a registered-result ALU time to settle.
        if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          rsp_res_d = alu_res;
          rsp_op_d  = alu_s_q;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MOD_WAIT: begin
        if (alu_done) begin
          rsp_res_d   = alu_res;
          rsp_op_d    = alu_s_q;
          alu_start_d = 1'b0;
          state_d     = ST_MOD_DRAIN;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (wd_expire) begin
          rsp_res_d   = '0;
          rsp_op_d    = alu_s_q;
          rsp_err_d   = 1'b1;
          alu_start_d = 1'b0;
          state_d     = ST_RESP;
        end
`endif
      end
      ST_MOD_DRAIN: begin
        // Wait for done to fall so a stale done cannot complete the next MOD.
        if (!alu_done) begin
          state_d = ST_RESP;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (wd_expire) begin
          rsp_res_d = '0;
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_start_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_op_q    <= '0;
      cnt_q       <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      alu_start_q <= alu_start_d;
      rsp_res_q   <= rsp_res_d;
      rsp_op_q    <= rsp_op_d;
      cnt_q       <= cnt_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Bench for alu32_seq_ctrl with a behavioural alu32 behind it.
// Expected responses are queued when a request is driven and compared on transfer.
module tb_alu32_seq_ctrl;
  import alu32_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_s;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        busy;

  int   checks;
  int   failures;
  exp_t sb_q[$];

  // Behavioural alu32 model
  logic [1:0]  mod_cnt;
  logic [31:0] mod_res;
  logic        force_no_done;

  alu32_seq_ctrl #(
    .SETTLE_CYCLES (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_start(alu_start),
    .alu_done (alu_done),
    .alu_res  (alu_res),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_res  (rsp_res),
    .rsp_op   (rsp_op),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Combinational result for single-cycle ops, latched modulo result otherwise.
  always_comb begin
    case (alu_s)
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_NOR:  alu_res = ~(alu_a | alu_b);
      OP_SLT:  alu_res = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      default: alu_res = mod_res;
    endcase
  end

  // Modulo model: done rises 4 cycles after start, holds while start is high, falls a cycle after start drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      mod_cnt  <= 2'd0;
      alu_done <= 1'b0;
      mod_res  <= 32'd0;
    end else if (alu_start && !alu_done) begin
      if (mod_cnt == 2'd3) begin
        alu_done <= !force_no_done;
        mod_res  <= (alu_b == 32'd0) ? alu_a : (alu_a % alu_b);
      end else begin
        mod_cnt <= mod_cnt + 2'd1;
      end
    end else if (!alu_start) begin
      mod_cnt  <= 2'd0;
      alu_done <= 1'b0;
    end
  end

  // Drive one request (called at a negedge), queue its expected response, return after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic push, input logic [31:0] exp_res, input logic exp_err);
    exp_t e;
    int   n;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    if (push) begin
      e.res = exp_res;
      e.op  = op;
      e.err = exp_err;
      sb_q.push_back(e);
    end
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL issue_wait: req_ready=%b required 1 within 200 cycles", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 3'($urandom_range(0, 7));
    $display("req  a=%0d b=%0d op=%b", a, b, op);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h1234_5678;
    req_op    = OP_ADD;
    rsp_ready = 1'b1;
    force_no_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_s !== 3'b000 || alu_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_alu: a=%h b=%h s=%b start=%b required 0/0/000/0", alu_a, alu_b, alu_s, alu_start);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_res !== 32'd0 || rsp_op !== 3'b000 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: valid=%b res=%h op=%b err=%b required 0/0/000/0", rsp_valid, rsp_res, rsp_op, rsp_err);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_status: busy=%b req_ready=%b required 0/1", busy, req_ready);
    end
    reset = 1'b0;
    $display("reset done");
  endtask

  task automatic test_add_latency();
    exp_t e;
    issue(32'd54, 32'd67, OP_ADD, 1'b1, 32'd121, 1'b0);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_edge1: rsp_valid=%b required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_edge2: rsp_valid=%b required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL lat_valid: rsp_valid=%b queued=%0d required 1 at accept+2", rsp_valid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
        failures++;
        $display("FAIL add_rsp: res=%0d op=%b err=%b required %0d/%b/%b", rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
      end
      $display("rsp  res=%0d op=%b err=%b", rsp_res, rsp_op, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        issue(32'd15, 32'd10, OP_AND, 1'b1, 32'd10, 1'b0);
        issue(32'd65, 32'd8,  OP_NOR, 1'b1, 32'hFFFF_FFB6, 1'b0);
        issue(32'd15, 32'd35, OP_SLT, 1'b1, 32'd1, 1'b0);
        issue(32'd46, 32'd32, OP_SUB, 1'b1, 32'd14, 1'b0);
      end
      begin
        exp_t e;
        int   n;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
            checks++;
            if (busy === 1'b1 && req_ready !== 1'b0) begin
              failures++;
              $display("FAIL b2b_ready: req_ready=%b required 0 while busy", req_ready);
            end
          end
          checks++;
          if (n >= 100 || sb_q.size() == 0) begin
            failures++;
            $display("FAIL b2b_timeout: rsp %0d not seen, queued=%0d", k, sb_q.size());
          end else begin
            e = sb_q.pop_front();
            if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
              failures++;
              $display("FAIL b2b_rsp%0d: res=%h op=%b err=%b required %h/%b/%b", k, rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
            end
            $display("rsp  res=%h op=%b err=%b", rsp_res, rsp_op, rsp_err);
            @(negedge clk);
          end
        end
      end
    join
  endtask

  task automatic test_mod();
    fork
      issue(32'd5, 32'd12, OP_MOD, 1'b1, 32'd5, 1'b0);
      begin
        exp_t e;
        int   n;
        logic done_seen, prev_done, prev_start, got;
        done_seen = 1'b0;
        prev_done = 1'b0;
        prev_start = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
          @(negedge clk);
          n++;
          if (busy === 1'b1) begin
            checks++;
            if (alu_a !== 32'd5 || alu_b !== 32'd12 || alu_s !== OP_MOD) begin
              failures++;
              $display("FAIL mod_hold: a=%0d b=%0d s=%b required 5/12/111", alu_a, alu_b, alu_s);
            end
            if (!done_seen) begin
              checks++;
              if (alu_start !== 1'b1) begin
                failures++;
                $display("FAIL mod_start_held: alu_start=%b required 1 before done", alu_start);
              end
            end
          end
          if (prev_done && prev_start) begin
            checks++;
            if (alu_start !== 1'b0) begin
              failures++;
              $display("FAIL mod_start_drop: alu_start=%b required 0 after done", alu_start);
            end
          end
          checks++;
          if (req_ready === 1'b1 && alu_done === 1'b1) begin
            failures++;
            $display("FAIL mod_drain: req_ready=%b with alu_done=%b required done=0", req_ready, alu_done);
          end
          if (alu_done === 1'b1) done_seen = 1'b1;
          prev_done  = alu_done;
          prev_start = alu_start;
          if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            got = 1'b1;
            checks++;
            if (sb_q.size() == 0) begin
              failures++;
              $display("FAIL mod_queue: response with empty queue");
            end else begin
              e = sb_q.pop_front();
              if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
                failures++;
                $display("FAIL mod_rsp: res=%0d op=%b err=%b required %0d/%b/%b", rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
              end
              $display("rsp  res=%0d op=%b err=%b", rsp_res, rsp_op, rsp_err);
            end
          end
        end
        checks++;
        if (!got || !done_seen) begin
          failures++;
          $display("FAIL mod_timeout: got=%b done_seen=%b required 1/1", got, done_seen);
        end
        @(negedge clk);
      end
    join
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    rsp_ready = 1'b0;
    issue(32'd54, 32'd67, OP_ADD, 1'b1, 32'd121, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    // Junk request while busy must be ignored.
    req_valid = 1'b1;
    req_a     = 32'd999;
    req_b     = 32'd1;
    req_op    = OP_SUB;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== 32'd121 || rsp_op !== OP_ADD || req_ready !== 1'b0 || alu_s !== OP_ADD) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b res=%0d op=%b req_ready=%b alu_s=%b required 1/121/101/0/101",
                 k, rsp_valid, rsp_res, rsp_op, req_ready, alu_s);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL bp_release: rsp_valid=%b queued=%0d required 1", rsp_valid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
        failures++;
        $display("FAIL bp_rsp: res=%0d op=%b err=%b required %0d/%b/%b", rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
      end
      $display("rsp  res=%0d op=%b err=%b (after backpressure)", rsp_res, rsp_op, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_after: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_mod();
    exp_t e;
    int   n;
    issue(32'd5, 32'd12, OP_MOD, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (alu_start !== 1'b1) begin
      failures++;
      $display("FAIL rstmod_pre: alu_start=%b required 1 in MOD_WAIT", alu_start);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmod_post: start=%b rsp_valid=%b busy=%b required 0/0/0", alu_start, rsp_valid, busy);
    end
    $display("reset during MOD_WAIT");
    issue(32'd1, 32'd1, OP_ADD, 1'b1, 32'd2, 1'b0);
    n = 0;
    while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL rstmod_add_timeout: response not seen, queued=%0d", sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
        failures++;
        $display("FAIL rstmod_add: res=%0d op=%b err=%b required %0d/%b/%b", rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
      end
      $display("rsp  res=%0d op=%b err=%b", rsp_res, rsp_op, rsp_err);
    end
    @(negedge clk);
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   n;
    int   high_cnt;
    force_no_done = 1'b1;
    issue(32'd5, 32'd12, OP_MOD, 1'b1, 32'd0, 1'b1);
    high_cnt = 0;
    n = 0;
    while (alu_start === 1'b1 && n < 50) begin
      high_cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (high_cnt != 8) begin
      failures++;
      $display("FAIL tmo_start_len: alu_start high %0d cycles required 8", high_cnt);
    end
    force_no_done = 1'b0;
    n = 0;
    while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL tmo_rsp_timeout: response not seen, queued=%0d", sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
        failures++;
        $display("FAIL tmo_rsp: res=%0d op=%b err=%b required %0d/%b/%b", rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
      end
      $display("rsp  res=%0d op=%b err=%b (timeout)", rsp_res, rsp_op, rsp_err);
    end
    @(negedge clk);
    issue(32'd54, 32'd67, OP_ADD, 1'b1, 32'd121, 1'b0);
    n = 0;
    while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL tmo_next_timeout: response not seen, queued=%0d", sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (rsp_res !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
        failures++;
        $display("FAIL tmo_next: res=%0d op=%b err=%b required %0d/%b/%b", rsp_res, rsp_op, rsp_err, e.res, e.op, e.err);
      end
      $display("rsp  res=%0d op=%b err=%b", rsp_res, rsp_op, rsp_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_mod();
    test_backpressure();
    test_reset_mid_mod();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
